// File: rtl/fft32_twiddle_seq.sv
// 32-point radix-2 DIT FFT butterfly sequencer.
// Emits operand addresses and sign-magnitude twiddle codes per beat.
module fft32_twiddle_seq #(
  parameter int WEIGHT_BITS = 12,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  logic                   ready,
  output logic                   valid,
  output logic [2:0]             stage,
  output logic [3:0]             bfly,
  output logic [ADDR_BITS-1:0]   addr_top,
  output logic [ADDR_BITS-1:0]   addr_bot,
  output logic [WEIGHT_BITS-1:0] weight_re,
  output logic [WEIGHT_BITS-1:0] weight_im,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic       valid_d;
  logic       done_d;
  logic [2:0] s_d;
  logic [3:0] b_d;

  logic [4:0] half;
  logic [3:0] jmask;
  logic [3:0] j;
  logic [3:0] g;
  logic [3:0] k;
  logic [3:0] re_idx;
  logic [3:0] im_idx;
  logic [10:0] re_mag;
  logic [10:0] im_mag;
  logic        re_sgn;
  logic        im_sgn;
  logic [ADDR_BITS-1:0]   top_d;
  logic [ADDR_BITS-1:0]   bot_d;
  logic [WEIGHT_BITS-1:0] wre_d;
  logic [WEIGHT_BITS-1:0] wim_d;

  // |cos(m * 11.25 deg)| with 11 fraction bits, 0x7FF standing in for 1.0
  function automatic logic [10:0] mag(input logic [3:0] m);
    logic [10:0] r;
    unique case (m)
      4'd0:    r = 11'h7FF;
      4'd1:    r = 11'h7D8;
      4'd2:    r = 11'h764;
      4'd3:    r = 11'h6A7;
      4'd4:    r = 11'h5A8;
      4'd5:    r = 11'h472;
      4'd6:    r = 11'h310;
      4'd7:    r = 11'h18F;
      default: r = 11'h000;
    endcase
    return r;
  endfunction

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state and next beat counters; flush overrides everything
  always_comb begin
    state_d = state_q;
    s_d     = stage;
    b_d     = bfly;
    valid_d = valid;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = 3'd0;
          b_d     = 4'd0;
          valid_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ready) begin
          if (bfly == 4'd15) begin
            b_d = 4'd0;
            if (stage == 3'd4) begin
              state_d = ST_DONE;
              s_d     = 3'd0;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              s_d = stage + 3'd1;
            end
          end else begin
            b_d = bfly + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = 3'd0;
        b_d     = 4'd0;
        valid_d = 1'b0;
      end
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      s_d     = 3'd0;
      b_d     = 4'd0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // addresses and twiddle for the upcoming beat; zero when no beat
  always_comb begin
    half   = 5'd1 << s_d;
    jmask  = 4'(half - 5'd1);
    j      = b_d & jmask;
    g      = b_d >> s_d;
    k      = j << (3'd4 - s_d);
    re_idx = (k <= 4'd8) ? k : 4'(5'd16 - {1'b0, k});
    im_idx = (k <= 4'd8) ? 4'(4'd8 - k) : 4'(k - 4'd8);
    re_mag = mag(re_idx);
    im_mag = (k == 4'd0) ? 11'h000 : mag(im_idx);
    re_sgn = (k > 4'd8) && (re_mag != 11'h000);
    im_sgn = (k != 4'd0) && (im_mag != 11'h000);
    top_d  = 5'({1'b0, g} << (s_d + 3'd1)) | {1'b0, j};
    bot_d  = top_d + half;
    wre_d  = {re_sgn, re_mag};
    wim_d  = {im_sgn, im_mag};
    if (!valid_d) begin
      top_d = '0;
      bot_d = '0;
      wre_d = '0;
      wim_d = '0;
    end
  end

  // registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      done      <= 1'b0;
      stage     <= 3'd0;
      bfly      <= 4'd0;
      addr_top  <= '0;
      addr_bot  <= '0;
      weight_re <= '0;
      weight_im <= '0;
    end else begin
      valid     <= valid_d;
      done      <= done_d;
      stage     <= s_d;
      bfly      <= b_d;
      addr_top  <= top_d;
      addr_bot  <= bot_d;
      weight_re <= wre_d;
      weight_im <= wim_d;
    end
  end

endmodule

// File: tb/tb_fft32_twiddle_seq.sv
// Directed bench for fft32_twiddle_seq.
// Hand-computed beat vectors, backpressure, flush and reset.
module tb_fft32_twiddle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [2:0]  stage;
  logic [3:0]  bfly;
  logic [4:0]  addr_top;
  logic [4:0]  addr_bot;
  logic [11:0] weight_re;
  logic [11:0] weight_im;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  // {s[47:44], b[43:40], top[39:32], bot[31:24], re[23:12], im[11:0]}
  logic [47:0] vtab [7];

  fft32_twiddle_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .ready     (ready),
    .valid     (valid),
    .stage     (stage),
    .bfly      (bfly),
    .addr_top  (addr_top),
    .addr_bot  (addr_bot),
    .weight_re (weight_re),
    .weight_im (weight_im),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({valid, stage, bfly, addr_top, addr_bot,
                weight_re, weight_im, done});
  endfunction

  task automatic run_full(input bit do_stall, input bit do_poke);
    int beats, es, eb, bad_order, bad_s0, dones, post_valid, after;
    bit stalled, poked, want_b7, prev_last;
    logic [63:0] snap;
    beats = 0; es = 0; eb = 0; bad_order = 0; bad_s0 = 0;
    dones = 0; post_valid = 0; after = -1;
    stalled = 0; poked = 0; want_b7 = 0; prev_last = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && after < 4; c++) begin
      if (done) begin
        dones++;
        chk("done_beats", 64'(beats), 64'd80);
        chk("done_after_last", 64'(prev_last), 64'd1);
        after = 0;
      end else if (after >= 0) begin
        after++;
        if (valid) post_valid++;
      end
      prev_last = 0;
      if (valid) begin
        if (stage !== 3'(es) || bfly !== 4'(eb)) bad_order++;
        if (stage == 3'd0 &&
            (weight_re !== 12'h7FF || weight_im !== 12'h000))
          bad_s0++;
        if (want_b7) begin
          want_b7 = 0;
          chk("resume_b7", 64'({stage, bfly}), 64'({3'd1, 4'd7}));
        end
        for (int v = 0; v < 7; v++) begin
          if ({1'b0, stage} == vtab[v][47:44] &&
              bfly == vtab[v][43:40]) begin
            chk($sformatf("top_s%0d_b%0d", stage, bfly),
                64'(addr_top), 64'(vtab[v][39:32]));
            chk($sformatf("bot_s%0d_b%0d", stage, bfly),
                64'(addr_bot), 64'(vtab[v][31:24]));
            chk($sformatf("re_s%0d_b%0d", stage, bfly),
                64'(weight_re), 64'(vtab[v][23:12]));
            chk($sformatf("im_s%0d_b%0d", stage, bfly),
                64'(weight_im), 64'(vtab[v][11:0]));
          end
        end
        if (do_poke && !poked && stage == 3'd2 && bfly == 4'd0) begin
          poked = 1;
          start = 1'b1;
        end
        if (do_stall && !stalled && stage == 3'd1 && bfly == 4'd6) begin
          stalled = 1;
          want_b7 = 1;
          snap = outs();
          ready = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", outs(), snap);
          end
          ready = 1'b1;
        end
        prev_last = (stage == 3'd4 && bfly == 4'd15);
        beats++;
        eb++;
        if (eb == 16) begin
          eb = 0;
          es++;
        end
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("beat_count", 64'(beats), 64'd80);
    chk("done_pulses", 64'(dones), 64'd1);
    chk("beat_order_errs", 64'(bad_order), 64'd0);
    chk("stage0_weight_errs", 64'(bad_s0), 64'd0);
    chk("valid_after_done", 64'(post_valid), 64'd0);
  endtask

  initial begin
    int vcnt, dcnt;
    bit found;
    vtab[0] = {4'd2, 4'd5,  8'd9,  8'd13, 12'h5A8, 12'hDA8};
    vtab[1] = {4'd4, 4'd3,  8'd3,  8'd19, 12'h6A7, 12'hC72};
    vtab[2] = {4'd4, 4'd8,  8'd8,  8'd24, 12'h000, 12'hFFF};
    vtab[3] = {4'd4, 4'd12, 8'd12, 8'd28, 12'hDA8, 12'hDA8};
    vtab[4] = {4'd1, 4'd6,  8'd12, 8'd14, 12'h7FF, 12'h000};
    vtab[5] = {4'd3, 4'd5,  8'd5,  8'd13, 12'hB10, 12'hF64};
    vtab[6] = {4'd4, 4'd15, 8'd15, 8'd31, 12'hFD8, 12'h98F};

    rst = 1'b1; start = 1'b0; flush = 1'b0; ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_beat_valid", 64'(valid), 64'd1);
    repeat (4) @(negedge clk);
    chk("pre_rst_bfly", 64'(bfly), 64'd4);
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_beat0",
        outs(), 64'({1'b1, 3'd0, 4'd0, 5'd0, 5'd1,
                     12'h7FF, 12'h000, 1'b0}));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", outs(), 64'd0);
    @(negedge clk);

    run_full(1'b1, 1'b1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (valid && stage == 3'd3) found = 1;
      else @(negedge clk);
    end
    chk("reach_stage3", 64'(found), 64'd1);
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_valid", 64'(valid), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_counters", 64'({stage, bfly}), 64'd0);
    vcnt = 0;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) vcnt++;
      if (done) dcnt++;
    end
    chk("idle_after_flush_valid", 64'(vcnt), 64'd0);
    chk("idle_after_flush_done", 64'(dcnt), 64'd0);

    run_full(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
